// File: rtl/arb_rr_2.sv
// -----------------------------------------------------------------------------
// arb_rr_2 -- two-channel round-robin arbiter with a single registered output
// stage. It sits directly upstream of a 2:1 data mux: out_sel is the channel
// index of the registered beat and drives that mux select.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   [1:0] per-channel beat present
//   in_data0   [DATA_W-1:0] channel 0 beat
//   in_data1   [DATA_W-1:0] channel 1 beat
//   in_last    [1:0] per-channel end-of-packet marker (packet lock build only)
//   in_ready   [1:0] per-channel accept, at most one bit set
//   out_valid  output register holds a beat
//   out_data   [DATA_W-1:0] registered beat
//   out_sel    channel index of the registered beat
//   out_ready  downstream accepts out_data this cycle
//
// Build option
//   ARB_LOCK_EN  when defined, a two-state FSM locks the grant to one channel
//                from the first beat of a packet until its in_last beat.
//                When undefined, in_last is ignored and every beat is
//                arbitrated independently.
// -----------------------------------------------------------------------------
module arb_rr_2 #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        in_valid,
   input  logic [DATA_W-1:0] in_data0,
   input  logic [DATA_W-1:0] in_data1,
   input  logic [1:0]        in_last,
   output logic [1:0]        in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sel,
   input  logic              out_ready
);

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic              out_sel_q,   out_sel_d;
   logic              ptr_q,       ptr_d;      // last granted channel

   logic              load;        // output register can take a beat
   logic [1:0]        req;         // requests eligible for arbitration
   logic              grant_vld;
   logic              grant_ch;
   logic              xfer;

`ifdef ARB_LOCK_EN
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t state_q, state_d;
   logic   lock_ch_q, lock_ch_d;

   // While a packet is in flight only the owning channel may compete.
   always_comb begin
      req = in_valid;
      if (state_q == ST_LOCK) begin
         req = lock_ch_q ? (in_valid & 2'b10) : (in_valid & 2'b01);
      end
   end

   always_comb begin
      state_d   = state_q;
      lock_ch_d = lock_ch_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer && !in_last[grant_ch]) begin
               state_d   = ST_LOCK;
               lock_ch_d = grant_ch;
            end
         end
         ST_LOCK: begin
            // grant_ch can only be lock_ch_q here, so this is the owner's last beat
            if (xfer && in_last[grant_ch]) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         lock_ch_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lock_ch_q <= lock_ch_d;
      end
   end
`else
   logic unused_last;
   assign unused_last = ^in_last;
   assign req         = in_valid;
`endif

   // Single requester wins outright; on contention the channel that did not
   // win last time is served.
   always_comb begin
      grant_vld = 1'b0;
      grant_ch  = 1'b0;
      case (req)
         2'b01: begin
            grant_vld = 1'b1;
            grant_ch  = 1'b0;
         end
         2'b10: begin
            grant_vld = 1'b1;
            grant_ch  = 1'b1;
         end
         2'b11: begin
            grant_vld = 1'b1;
            grant_ch  = ~ptr_q;
         end
         default: begin
            grant_vld = 1'b0;
            grant_ch  = 1'b0;
         end
      endcase
   end

   assign load = !out_valid_q || out_ready;

   // rst_n gates the ready so no source sees an accept while reset is held.
   always_comb begin
      in_ready = 2'b00;
      if (rst_n && load && grant_vld) begin
         in_ready[grant_ch] = 1'b1;
      end
   end

   // in_ready is only raised for a requesting channel, so any ready bit is a transfer.
   assign xfer = |in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = grant_ch ? in_data1 : in_data0;
         out_sel_d   = grant_ch;
         ptr_d       = grant_ch;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // ptr resets to 1 so channel 0 wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= 1'b0;
         ptr_q       <= 1'b1;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_rr_2.sv
// -----------------------------------------------------------------------------
// tb_arb_rr_2 -- self-checking bench for arb_rr_2.
// Directed sequences pin literal expectations; a randomized phase is checked
// every cycle against a behavioural model of the arbiter rules.
// -----------------------------------------------------------------------------
module tb_arb_rr_2;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    in_valid = 2'b00;
   logic [DW-1:0] in_data0 = '0;
   logic [DW-1:0] in_data1 = '0;
   logic [1:0]    in_last = 2'b11;
   logic [1:0]    in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_sel;
   logic          out_ready = 1'b1;

   int errors = 0;
   int checks = 0;

   arb_rr_2 #(.DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data0  (in_data0),
      .in_data1  (in_data1),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change only just after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model: the output is a one-entry buffer; the grant goes to
   // the sole eligible requester, or on contention to the channel that did
   // not win last time. A packet in flight restricts eligibility to its owner.
   // State below describes the registers as seen in the current cycle.
   // ---------------------------------------------------------------------
   bit            m_full = 0;
   logic [DW-1:0] m_data = '0;
   int            m_sel  = 0;
   int            m_last_win = 1;
   int            m_owner = -1;   // channel owning an open packet, -1 if none

   always @(negedge clk) begin
      logic [1:0] elig;
      logic [1:0] exp_rdy;
      int         win;
      bit         room;
      if (!rst_n) begin
         m_full     = 0;
         m_data     = '0;
         m_sel      = 0;
         m_last_win = 1;
         m_owner    = -1;
      end
      elig = in_valid;
      if (m_owner >= 0) elig = in_valid & (2'b01 << m_owner);
      win = -1;
      if (elig == 2'b01)      win = 0;
      else if (elig == 2'b10) win = 1;
      else if (elig == 2'b11) win = 1 - m_last_win;
      room = !m_full || out_ready;
      exp_rdy = (rst_n && room && win >= 0) ? (2'b01 << win) : 2'b00;

      chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_full});
      chk("cyc_out_data",  {24'd0, out_data},  {24'd0, m_data});
      chk("cyc_out_sel",   {31'd0, out_sel},   m_sel);
      chk("cyc_in_ready",  {30'd0, in_ready},  {30'd0, exp_rdy});

      if (rst_n) begin
         if (exp_rdy != 2'b00) begin
            m_full     = 1;
            m_data     = (win == 1) ? in_data1 : in_data0;
            m_sel      = win;
            m_last_win = win;
`ifdef ARB_LOCK_EN
            m_owner    = in_last[win] ? -1 : win;
`endif
         end else if (out_ready) begin
            m_full = 0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus with literal expectations
   // ---------------------------------------------------------------------
   logic [1:0] lock_rdy [4];
   int         lock_sel [4];
   int         j0;

   initial begin
`ifdef ARB_LOCK_EN
      lock_rdy = '{2'b01, 2'b01, 2'b01, 2'b10};
      lock_sel = '{0, 0, 0, 1};
`else
      lock_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
      lock_sel = '{0, 1, 0, 1};
`endif

      // Reset held; requests during reset must not see a ready.
      tick();
      in_valid = 2'b11;
      @(negedge clk);
      chk("rst_in_ready", {30'd0, in_ready}, 32'd0);
      tick();
      in_valid = 2'b00;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
         chk("idle_out_data",  {24'd0, out_data},  32'd0);
         chk("idle_out_sel",   {31'd0, out_sel},   32'd0);
         chk("idle_in_ready",  {30'd0, in_ready},  32'd0);
         tick();
      end

      // Continuous dual requests alternate starting with channel 0.
      in_valid = 2'b11; in_data0 = 8'hA0; in_data1 = 8'hB1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("dual_in_ready", {30'd0, in_ready}, (i % 2) ? 32'd2 : 32'd1);
         if (i > 0) begin
            chk("dual_out_valid", {31'd0, out_valid}, 32'd1);
            chk("dual_out_data",  {24'd0, out_data},  ((i - 1) % 2) ? 32'hB1 : 32'hA0);
            chk("dual_out_sel",   {31'd0, out_sel},   (i - 1) % 2);
         end
         tick();
      end
      in_valid = 2'b00;
      @(negedge clk);
      chk("dual_tail_data", {24'd0, out_data}, 32'hB1);
      chk("dual_tail_sel",  {31'd0, out_sel},  32'd1);

      // Channel 1 alone, three beats, then channel 0 alone is served at once.
      tick(); in_valid = 2'b10; in_data1 = 8'h11;
      @(negedge clk);
      chk("ch1_in_ready", {30'd0, in_ready}, 32'd2);
      tick(); in_data1 = 8'h12;
      @(negedge clk);
      chk("ch1_b0_data", {24'd0, out_data}, 32'h11);
      chk("ch1_b0_sel",  {31'd0, out_sel},  32'd1);
      tick(); in_data1 = 8'h13;
      @(negedge clk);
      chk("ch1_b1_data", {24'd0, out_data}, 32'h12);
      chk("ch1_b1_sel",  {31'd0, out_sel},  32'd1);
      tick(); in_valid = 2'b01; in_data0 = 8'h55;
      @(negedge clk);
      chk("ch1_b2_data",  {24'd0, out_data}, 32'h13);
      chk("ch1_b2_sel",   {31'd0, out_sel},  32'd1);
      chk("ch0_in_ready", {30'd0, in_ready}, 32'd1);

      // Back-pressure: 0x55 held for 3 cycles, then channel 1 wins.
      tick(); in_valid = 2'b11; in_data1 = 8'h66; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_out_data",  {24'd0, out_data},  32'h55);
         chk("bp_out_sel",   {31'd0, out_sel},   32'd0);
         chk("bp_in_ready",  {30'd0, in_ready},  32'd0);
         if (i < 2) tick();
      end
      tick(); out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_rdy", {30'd0, in_ready}, 32'd2);
      tick();
      @(negedge clk);
      chk("bp_next_data", {24'd0, out_data}, 32'h66);
      chk("bp_next_sel",  {31'd0, out_sel},  32'd1);

      // Reset while a beat is held under back-pressure.
      tick(); out_ready = 1'b0;
      @(negedge clk);
      chk("prerst_out_valid", {31'd0, out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_data",  {24'd0, out_data},  32'd0);
      chk("async_rst_rdy",   {30'd0, in_ready},  32'd0);
      @(negedge clk);
      tick();
      rst_n = 1'b1; out_ready = 1'b1; in_valid = 2'b11; in_data0 = 8'hA0; in_data1 = 8'hB1;
      @(negedge clk);
      chk("post_rst_rdy", {30'd0, in_ready}, 32'd1);

      // One channel 1 beat so channel 0 wins the next contention.
      tick(); in_valid = 2'b10;
      @(negedge clk);
      chk("prelock_rdy", {30'd0, in_ready}, 32'd2);

      // Channel 0 sends a 3-beat packet while channel 1 stays valid.
      j0 = 0;
      tick(); in_valid = 2'b11; in_data0 = 8'hC0; in_last = 2'b10;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i < 4) chk("pkt_in_ready", {30'd0, in_ready}, {30'd0, lock_rdy[i]});
         if (i > 0) chk("pkt_out_sel", {31'd0, out_sel}, lock_sel[i - 1]);
         if (in_ready[0]) j0++;
         tick();
         in_data0    = 8'hC0 + 8'(j0);
         in_last[0]  = (j0 == 2);
         in_valid[0] = (j0 < 3);
      end

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         rst_n     = ($urandom_range(0, 249) != 0);
         in_valid  = 2'($urandom_range(0, 3));
         in_data0  = 8'($urandom);
         in_data1  = 8'($urandom);
         in_last   = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      rst_n = 1'b1;
      in_valid = 2'b00;
      tick();
      @(negedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
